aes_ctr_para_feeder: RTL and testbench

- Upstream controller for the 16-lane parallel AES-256 round array.
- Takes an IV/nonce and a batch count, builds 16 consecutive CTR counter blocks per batch, and holds them on the array's text input.
- Sequences rounds 0..14 and the matching round key from the key store, then captures the 16 keystream blocks.
- Presents each captured batch on a valid/ready output toward the XOR stage.

---
 rtl/aes_ctr_para_feeder.sv | 168 ++++++++++++++++
 tb/tb_aes_ctr_para_feeder.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/aes_ctr_para_feeder.sv
// CTR-mode feeder for a 16-lane parallel AES-256 round array: builds counter
// blocks per batch, steps the round index/key, captures and hands off keystream.
module aes_ctr_para_feeder #(
    parameter int BLOCK_SIZE = 128,
    parameter int PARA       = 16,
    parameter int NUM_ROUNDS = 14,
    parameter int CTR_W      = 32
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         start_valid,
    output logic                         start_ready,
    input  logic [BLOCK_SIZE-1:0]        iv,
    input  logic [15:0]                  nbatch,
    output logic [3:0]                   rk_addr,
    input  logic [BLOCK_SIZE-1:0]        rk_data,
    output logic [BLOCK_SIZE*PARA-1:0]   core_text,
    output logic [3:0]                   core_round,
    output logic [BLOCK_SIZE-1:0]        core_round_key,
    input  logic [BLOCK_SIZE*PARA-1:0]   core_result,
    output logic                         ks_valid,
    input  logic                         ks_ready,
    output logic [BLOCK_SIZE*PARA-1:0]   ks_data,
    output logic                         ks_last,
    output logic                         busy
);

    localparam int NONCE_W = BLOCK_SIZE - CTR_W;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LOAD    = 3'd1,
        ROUND   = 3'd2,
        CAPTURE = 3'd3,
        OUT     = 3'd4
    } state_t;

    state_t                       state_r;
    state_t                       state_next_s;
    logic [NONCE_W-1:0]           nonce_r;
    logic [CTR_W-1:0]             ctr_r;
    logic [15:0]                  remaining_r;
    logic [3:0]                   round_r;
    logic [BLOCK_SIZE*PARA-1:0]   core_text_r;
    logic [BLOCK_SIZE*PARA-1:0]   ks_data_r;
    logic                         ks_valid_r;
    logic                         ks_last_r;
    logic                         busy_r;
    logic                         ks_fire_s;

    // Lane i carries {nonce, base + i}; the counter wraps without touching the nonce.
    function automatic logic [BLOCK_SIZE*PARA-1:0] build_text(
        input logic [NONCE_W-1:0] nonce,
        input logic [CTR_W-1:0]   base
    );
        logic [BLOCK_SIZE*PARA-1:0] text;
        logic [CTR_W-1:0]           c;
        text = '0;
        for (int i = 0; i < PARA; i++) begin
            c = base + CTR_W'(i);
            text[i*BLOCK_SIZE +: BLOCK_SIZE] = {nonce, c};
        end
        return text;
    endfunction

    assign ks_fire_s      = ks_valid_r && ks_ready;
    assign start_ready    = (state_r == IDLE);
    assign rk_addr        = round_r;
    assign core_round     = round_r;
    assign core_round_key = rk_data;
    assign core_text      = core_text_r;
    assign ks_data        = ks_data_r;
    assign ks_valid       = ks_valid_r;
    assign ks_last        = ks_last_r;
    assign busy           = busy_r;

    // Next-state decode for the batch sequencer.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (start_valid && (nbatch != 16'd0)) begin
                    state_next_s = LOAD;
                end else begin
                    state_next_s = IDLE;
                end
            end
            LOAD:    state_next_s = ROUND;
            ROUND: begin
                if (round_r == 4'(NUM_ROUNDS)) begin
                    state_next_s = CAPTURE;
                end else begin
                    state_next_s = ROUND;
                end
            end
            CAPTURE: state_next_s = OUT;
            OUT: begin
                if (ks_fire_s) begin
                    state_next_s = (remaining_r == 16'd1) ? IDLE : LOAD;
                end else begin
                    state_next_s = OUT;
                end
            end
            default: state_next_s = IDLE;
        endcase
    end

    // State register and busy flag.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= IDLE;
            busy_r  <= 1'b0;
        end else begin
            state_r <= state_next_s;
            busy_r  <= (state_next_s != IDLE);
        end
    end

    // Job registers, counter blocks, round index and the keystream output stage.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            nonce_r     <= '0;
            ctr_r       <= '0;
            remaining_r <= 16'd0;
            round_r     <= 4'd0;
            core_text_r <= '0;
            ks_data_r   <= '0;
            ks_valid_r  <= 1'b0;
            ks_last_r   <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (start_valid) begin
                        nonce_r     <= iv[BLOCK_SIZE-1:CTR_W];
                        ctr_r       <= iv[CTR_W-1:0];
                        remaining_r <= nbatch;
                    end
                end
                LOAD: begin
                    core_text_r <= build_text(nonce_r, ctr_r);
                    round_r     <= 4'd0;
                end
                ROUND: begin
                    round_r <= (round_r == 4'(NUM_ROUNDS)) ? 4'd0 : round_r + 4'd1;
                end
                CAPTURE: begin
                    ks_data_r <= core_result;
                    ks_last_r <= (remaining_r == 16'd1);
                end
                OUT: begin
                    // Valid is raised one cycle after capture so the hand-off is fully registered.
                    if (!ks_valid_r) begin
                        ks_valid_r <= 1'b1;
                    end else if (ks_ready) begin
                        ks_valid_r  <= 1'b0;
                        ks_last_r   <= 1'b0;
                        remaining_r <= remaining_r - 16'd1;
                        ctr_r       <= ctr_r + CTR_W'(PARA);
                    end
                end
                default: begin
                    round_r <= 4'd0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_aes_ctr_para_feeder.sv
// Directed bench for aes_ctr_para_feeder: counter layout, round stepping,
// latency, backpressure, multi-batch, abort and no-op jobs.
module tb_aes_ctr_para_feeder;

    localparam logic [127:0] MASK = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start_valid;
    logic          start_ready;
    logic [127:0]  iv;
    logic [15:0]   nbatch;
    logic [3:0]    rk_addr;
    logic [127:0]  rk_data;
    logic [2047:0] core_text;
    logic [3:0]    core_round;
    logic [127:0]  core_round_key;
    logic [2047:0] core_result;
    logic          ks_valid;
    logic          ks_ready;
    logic [2047:0] ks_data;
    logic          ks_last;
    logic          busy;

    int compared   = 0;
    int mismatched = 0;
    int edge_n     = 0;
    int hs_edge    = 0;
    int seen       = 0;

    aes_ctr_para_feeder dut (
        .clk(clk), .rst_n(rst_n), .start_valid(start_valid), .start_ready(start_ready),
        .iv(iv), .nbatch(nbatch), .rk_addr(rk_addr), .rk_data(rk_data),
        .core_text(core_text), .core_round(core_round), .core_round_key(core_round_key),
        .core_result(core_result), .ks_valid(ks_valid), .ks_ready(ks_ready),
        .ks_data(ks_data), .ks_last(ks_last), .busy(busy)
    );

    always #5 clk = ~clk;

    // Key store returns its own address; the array model masks each lane.
    assign rk_data = {124'h0, rk_addr};
    always_comb begin
        core_result = '0;
        for (int i = 0; i < 16; i++) core_result[i*128 +: 128] = core_text[i*128 +: 128] ^ MASK;
    end

    task automatic tick();
        @(posedge clk);
        #1;
        edge_n++;
    endtask

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    function automatic logic [127:0] lane(input logic [2047:0] bus, input int i);
        return bus[i*128 +: 128];
    endfunction

    task automatic start_job(input logic [127:0] v, input logic [15:0] n);
        iv = v;
        nbatch = n;
        start_valid = 1'b1;
        tick();
        hs_edge = edge_n;
        start_valid = 1'b0;
        iv = '0;
        nbatch = 16'd0;
    endtask

    task automatic wait_valid(input string tag);
        for (int i = 0; i < 40; i++) begin
            if (ks_valid) break;
            tick();
        end
        check(tag, {127'h0, ks_valid}, 128'd1);
    endtask

    initial begin
        logic [95:0]  nonce;
        logic [127:0] held;

        // Reset with random inputs.
        rst_n = 1'b0;
        start_valid = 1'($urandom);
        iv = {$urandom, $urandom, $urandom, $urandom};
        nbatch = 16'($urandom);
        ks_ready = 1'($urandom);
        tick();
        tick();
        check("rst_ks_valid", {127'h0, ks_valid}, 128'd0);
        check("rst_ks_last", {127'h0, ks_last}, 128'd0);
        check("rst_busy", {127'h0, busy}, 128'd0);
        check("rst_start_ready", {127'h0, start_ready}, 128'd1);
        check("rst_core_round", {124'h0, core_round}, 128'd0);
        check("rst_core_text", {127'h0, |core_text}, 128'd0);
        check("rst_ks_data", {127'h0, |ks_data}, 128'd0);
        rst_n = 1'b1;
        start_valid = 1'b0;
        ks_ready = 1'b1;
        tick();

        // Counter wrap, round sequencing, latency.
        nonce = 96'hA5A5_0000_1111_2222_3333_4444;
        start_job({nonce, 32'hFFFF_FFF8}, 16'd1);
        check("load_busy", {127'h0, busy}, 128'd1);
        check("load_start_ready", {127'h0, start_ready}, 128'd0);
        tick();
        check("wrap_lane0", lane(core_text, 0), {nonce, 32'hFFFF_FFF8});
        check("wrap_lane7", lane(core_text, 7), {nonce, 32'hFFFF_FFFF});
        check("wrap_lane8", lane(core_text, 8), {nonce, 32'h0000_0000});
        check("wrap_lane15", lane(core_text, 15), {nonce, 32'h0000_0007});
        for (int r = 0; r < 15; r++) begin
            check($sformatf("round_%0d", r), {124'h0, core_round}, 128'(r));
            check($sformatf("rk_addr_%0d", r), {124'h0, rk_addr}, 128'(r));
            check($sformatf("rkey_%0d", r), core_round_key, 128'(r));
            check($sformatf("no_valid_%0d", r), {127'h0, ks_valid}, 128'd0);
            tick();
        end
        check("capture_round0", {124'h0, core_round}, 128'd0);
        wait_valid("valid_timeout_1");
        check("latency_1", 128'(edge_n - hs_edge), 128'd18);
        check("ks1_lane0", lane(ks_data, 0), {nonce, 32'hFFFF_FFF8} ^ MASK);
        check("ks1_lane8", lane(ks_data, 8), {nonce, 32'h0000_0000} ^ MASK);
        check("ks1_lane15", lane(ks_data, 15), {nonce, 32'h0000_0007} ^ MASK);
        check("ks1_last", {127'h0, ks_last}, 128'd1);
        check("ks1_text_held", lane(core_text, 15), {nonce, 32'h0000_0007});
        tick();
        check("ks1_valid_drop", {127'h0, ks_valid}, 128'd0);
        check("ks1_idle_ready", {127'h0, start_ready}, 128'd1);
        check("ks1_idle_busy", {127'h0, busy}, 128'd0);

        // Backpressure on the first of two batches.
        nonce = 96'h1234_5678_9ABC_DEF0_0F1E_2D3C;
        ks_ready = 1'b0;
        start_job({nonce, 32'h0000_0100}, 16'd2);
        wait_valid("valid_timeout_bp1");
        check("latency_bp", 128'(edge_n - hs_edge), 128'd18);
        check("bp1_lane0", lane(ks_data, 0), {nonce, 32'h0000_0100} ^ MASK);
        check("bp1_last", {127'h0, ks_last}, 128'd0);
        held = lane(ks_data, 0);
        for (int i = 0; i < 5; i++) begin
            tick();
            check($sformatf("bp_valid_%0d", i), {127'h0, ks_valid}, 128'd1);
            check($sformatf("bp_data_%0d", i), lane(ks_data, 0), held);
            check($sformatf("bp_last_%0d", i), {127'h0, ks_last}, 128'd0);
            check($sformatf("bp_noload_%0d", i), lane(core_text, 0), {nonce, 32'h0000_0100});
        end
        ks_ready = 1'b1;
        tick();
        ks_ready = 1'b0;
        check("bp_after_hs_valid", {127'h0, ks_valid}, 128'd0);
        tick();
        check("bp2_text0", lane(core_text, 0), {nonce, 32'h0000_0110});
        check("bp2_text15", lane(core_text, 15), {nonce, 32'h0000_011F});
        wait_valid("valid_timeout_bp2");
        check("bp2_lane0", lane(ks_data, 0), {nonce, 32'h0000_0110} ^ MASK);
        check("bp2_last", {127'h0, ks_last}, 128'd1);
        ks_ready = 1'b1;
        tick();
        check("bp_idle", {127'h0, start_ready}, 128'd1);

        // Three back-to-back batches from counter 0.
        nonce = 96'hCAFE_F00D_0000_0001_0000_0002;
        start_job({nonce, 32'h0}, 16'd3);
        for (int b = 0; b < 3; b++) begin
            wait_valid($sformatf("valid_timeout_mb%0d", b));
            check($sformatf("mb_lane0_%0d", b), lane(ks_data, 0), {nonce, 32'(16 * b)} ^ MASK);
            check($sformatf("mb_last_%0d", b), {127'h0, ks_last}, (b == 2) ? 128'd1 : 128'd0);
            tick();
        end
        check("mb_start_ready", {127'h0, start_ready}, 128'd1);
        check("mb_busy", {127'h0, busy}, 128'd0);

        // Abort during round 7.
        start_job({nonce, 32'h55}, 16'd5);
        for (int i = 0; i < 8; i++) tick();
        check("abort_round7", {124'h0, core_round}, 128'd7);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("abort_ready", {127'h0, start_ready}, 128'd1);
        check("abort_busy", {127'h0, busy}, 128'd0);
        check("abort_round", {124'h0, core_round}, 128'd0);
        check("abort_text", {127'h0, |core_text}, 128'd0);
        seen = 0;
        for (int i = 0; i < 25; i++) begin
            if (ks_valid) seen++;
            tick();
        end
        check("abort_no_valid", 128'(seen), 128'd0);

        // Zero-batch job is accepted and does nothing.
        start_job({nonce, 32'h77}, 16'd0);
        check("noop_busy", {127'h0, busy}, 128'd0);
        check("noop_ready", {127'h0, start_ready}, 128'd1);
        seen = 0;
        for (int i = 0; i < 25; i++) begin
            if (ks_valid || busy) seen++;
            tick();
        end
        check("noop_no_activity", 128'(seen), 128'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
